// File: rtl/inst_fetch_if.sv
// Bundle of the instruction-fetch stage's bus signals.
//   Memory write port : wr_en, wr_addr, wr_data
//   Run control       : start, stall, redirect, redirect_pc
//   Fetch outputs     : fe_valid, fe_inst, fe_pc, halted
// modport slave  - the fetch stage (inst_fetch)
// modport master - whatever drives the fetch stage (loader / consumer / bench)
interface inst_fetch_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
);
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            start;
    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            fe_valid;
    logic [XLEN-1:0] fe_inst;
    logic [XLEN-1:0] fe_pc;
    logic            halted;

    modport slave (
        input  wr_en, wr_addr, wr_data, start, stall, redirect, redirect_pc,
        output fe_valid, fe_inst, fe_pc, halted
    );

    modport master (
        output wr_en, wr_addr, wr_data, start, stall, redirect, redirect_pc,
        input  fe_valid, fe_inst, fe_pc, halted
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns instruction memory, PC and a run-control FSM
// (IDLE -> RUN -> HALT). Presents one registered instruction per cycle.
// Ports:
//   CLOCK_50 - clock, all state updates on rising edge
//   RSTN_N   - synchronous active-high reset (memory contents preserved)
//   bus      - inst_fetch_if.slave: write port, start/stall/redirect,
//              fe_valid/fe_inst/fe_pc/halted outputs
module inst_fetch #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     DEPTH     = 32,
    parameter int unsigned     AW        = 5,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] HALT_INST = '1
) (
    input  logic        CLOCK_50,
    input  logic        RSTN_N,
    inst_fetch_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] fpc_q, fpc_d;

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [XLEN-1:0] rd_word;

    // Memory is never reset. Reading the register array before the edge
    // gives old-data behaviour on a same-index read/write.
    always_ff @(posedge CLOCK_50) begin
        if (bus.wr_en) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Byte PC -> word index; upper bits drop out so the index wraps mod DEPTH.
    assign rd_word = mem_q[pc_q[AW+1:2]];

    always_ff @(posedge CLOCK_50) begin
        if (RSTN_N) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            inst_q  <= '0;
            fpc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            inst_q  <= inst_d;
            fpc_q   <= fpc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        inst_d  = inst_q;
        fpc_d   = fpc_q;
        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                if (bus.start) begin
                    state_d = S_RUN;
                    pc_d    = RESET_PC;
                end
            end
            S_RUN: begin
                if (bus.redirect) begin
                    // Redirect beats stall and costs one bubble.
                    pc_d    = bus.redirect_pc;
                    valid_d = 1'b0;
                end else if (!bus.stall) begin
                    if (rd_word == HALT_INST) begin
                        state_d = S_HALT;
                        valid_d = 1'b0;
                    end else begin
                        inst_d  = rd_word;
                        fpc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + XLEN'(4);
                    end
                end
            end
            S_HALT: begin
                valid_d = 1'b0;
                if (bus.redirect) begin
                    state_d = S_RUN;
                    pc_d    = bus.redirect_pc;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign bus.fe_valid = valid_q;
    assign bus.fe_inst  = inst_q;
    assign bus.fe_pc    = fpc_q;
    assign bus.halted   = (state_q == S_HALT);

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: behavioural model plus directed
// scenarios with literal expectations.
module tb_inst_fetch;

    localparam int unsigned    XLEN  = 32;
    localparam int unsigned    DEPTH = 32;
    localparam int unsigned    AW    = 5;
    localparam logic [31:0]    HALTW = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst;

    inst_fetch_if #(.XLEN(XLEN), .AW(AW)) bus ();

    inst_fetch #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .AW       (AW),
        .RESET_PC (32'h0),
        .HALT_INST(HALTW)
    ) dut (
        .CLOCK_50(clk),
        .RSTN_N  (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 running, 2 halted
    logic [31:0] m_mem [DEPTH];
    int          m_mode;
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_fpc;

    always @(posedge clk) begin
        logic [31:0] word;
        word = m_mem[(m_pc / 4) % DEPTH];
        if (rst) begin
            m_mode  = 0;
            m_pc    = 0;
            m_valid = 0;
            m_inst  = 0;
            m_fpc   = 0;
        end else if (m_mode == 0) begin
            m_valid = 0;
            if (bus.start) begin
                m_mode = 1;
                m_pc   = 0;
            end
        end else if (m_mode == 1) begin
            if (bus.redirect) begin
                m_pc    = bus.redirect_pc;
                m_valid = 0;
            end else if (!bus.stall) begin
                if (word == HALTW) begin
                    m_mode  = 2;
                    m_valid = 0;
                end else begin
                    m_inst  = word;
                    m_fpc   = m_pc;
                    m_valid = 1;
                    m_pc    = m_pc + 4;
                end
            end
        end else begin
            m_valid = 0;
            if (bus.redirect) begin
                m_mode = 1;
                m_pc   = bus.redirect_pc;
            end
        end
        if (bus.wr_en) m_mem[bus.wr_addr] = bus.wr_data;
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_valid", {31'b0, bus.fe_valid}, {31'b0, m_valid});
            chk("model_halted", {31'b0, bus.halted}, {31'b0, (m_mode == 2)});
            if (m_valid) begin
                chk("model_inst", bus.fe_inst, m_inst);
                chk("model_pc", bus.fe_pc, m_fpc);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic quiet();
        bus.wr_en       = 1'b0;
        bus.start       = 1'b0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
    endtask

    task automatic expect_out(input string name, input logic [31:0] pc, input logic [31:0] inst);
        chk({name, "_valid"}, {31'b0, bus.fe_valid}, 32'd1);
        chk({name, "_pc"}, bus.fe_pc, pc);
        chk({name, "_inst"}, bus.fe_inst, inst);
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        bus.redirect    = 1'b1;
        bus.redirect_pc = tgt;
        tick();
        bus.redirect    = 1'b0;
    endtask

    task automatic run_to_halt(input string name);
        int n;
        n = 0;
        while (!bus.halted && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_reached_halt"}, {31'b0, bus.halted}, 32'd1);
    endtask

    initial begin
        quiet();
        bus.wr_addr = '0;
        bus.wr_data = '0;
        rst = 1'b1;
        tick();
        tick();
        chk_en = 1'b1;
        chk("reset_valid", {31'b0, bus.fe_valid}, 32'd0);
        chk("reset_inst", bus.fe_inst, 32'd0);
        chk("reset_pc", bus.fe_pc, 32'd0);
        chk("reset_halted", {31'b0, bus.halted}, 32'd0);
        rst = 1'b0;

        // Program 11,22,33,44,HALT then filler words (never HALT).
        for (int unsigned i = 0; i < DEPTH; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = AW'(i);
            case (i)
                0: bus.wr_data = 32'h11;
                1: bus.wr_data = 32'h22;
                2: bus.wr_data = 32'h33;
                3: bus.wr_data = 32'h44;
                4: bus.wr_data = HALTW;
                default: bus.wr_data = 32'hA000_0000 + i;
            endcase
            tick();
        end
        bus.wr_en = 1'b0;

        // Basic run
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start_bubble", {31'b0, bus.fe_valid}, 32'd0);
        tick(); expect_out("run_c1", 32'd0, 32'h11);
        tick(); expect_out("run_c2", 32'd4, 32'h22);
        tick(); expect_out("run_c3", 32'd8, 32'h33);
        tick(); expect_out("run_c4", 32'd12, 32'h44);
        tick();
        chk("run_c5_valid", {31'b0, bus.fe_valid}, 32'd0);
        chk("run_c5_halted", {31'b0, bus.halted}, 32'd1);

        // start ignored in HALT
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("halt_start_ignored", {31'b0, bus.halted}, 32'd1);

        // Stall hold at fe_pc=4
        redirect_to(32'd0);
        tick(); expect_out("stall_pre0", 32'd0, 32'h11);
        tick(); expect_out("stall_pre1", 32'd4, 32'h22);
        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(); expect_out("stall_hold", 32'd4, 32'h22);
        end
        bus.stall = 1'b0;
        tick(); expect_out("stall_release", 32'd8, 32'h33);

        // Redirect + stall together at fe_pc=8
        bus.stall = 1'b1;
        redirect_to(32'd0);
        bus.stall = 1'b0;
        chk("redir_stall_bubble", {31'b0, bus.fe_valid}, 32'd0);
        tick(); expect_out("redir_stall_target", 32'd0, 32'h11);

        // HALT exit by redirect, and index wrap at 4*DEPTH
        run_to_halt("second_run");
        redirect_to(32'd4);
        chk("halt_exit_halted", {31'b0, bus.halted}, 32'd0);
        tick(); expect_out("halt_exit_target", 32'd4, 32'h22);
        redirect_to(32'd128);
        tick(); expect_out("wrap_index", 32'd128, 32'h11);

        // Same-cycle write/read returns old word
        redirect_to(32'd8);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(2);
        bus.wr_data = 32'h55;
        tick();
        bus.wr_en = 1'b0;
        expect_out("rw_old_word", 32'd8, 32'h33);
        redirect_to(32'd8);
        tick(); expect_out("rw_new_word", 32'd8, 32'h55);

        // Restore word 2 while fetching pc 12, then reset mid-run
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(2);
        bus.wr_data = 32'h33;
        tick();
        bus.wr_en = 1'b0;
        expect_out("pre_reset", 32'd12, 32'h44);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrun_reset_valid", {31'b0, bus.fe_valid}, 32'd0);
        chk("midrun_reset_pc", bus.fe_pc, 32'd0);
        chk("midrun_reset_halted", {31'b0, bus.halted}, 32'd0);

        // Redirect ignored in IDLE
        redirect_to(32'd8);
        tick();
        chk("idle_redirect_ignored", {31'b0, bus.fe_valid}, 32'd0);

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); expect_out("restart_mem_intact", 32'd0, 32'h11);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        expect_out("start_in_run_ignored", 32'd4, 32'h22);

        // pc+4 wraps at 2^XLEN
        redirect_to(32'hFFFF_FFFC);
        tick(); expect_out("pc_top", 32'hFFFF_FFFC, 32'hA000_001F);
        tick(); expect_out("pc_wrap", 32'd0, 32'h11);

        run_to_halt("final_run");
        tick();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch stage directly upstream of the CPU decode/execute path.
- Owns the instruction memory, the program counter and a small run-control FSM.
- Presents one instruction per cycle, with its PC and a valid flag, to the consumer.
- Accepts consumer stall and branch redirect. The memory is loaded through a write port before or during execution.

Parameters:
- XLEN, 32, instruction/PC width
- DEPTH, 32, instruction memory depth in words
- AW, 5, memory index width; must equal log2(DEPTH)
- RESET_PC, 0, PC loaded on reset and on start
- HALT_INST, 32'hFFFF_FFFF, instruction word that stops fetch

Ports:
- CLOCK_50  in  1  clock; all state updates on its rising edge
- RSTN_N  in  1  reset; synchronous and active-high in this block
- wr_en  in  1  instruction memory write strobe
- wr_addr  in  AW  word index for the write
- wr_data  in  XLEN  word to write
- start  in  1  one-cycle pulse; begin fetching from RESET_PC
- stall  in  1  consumer cannot accept; hold outputs
- redirect  in  1  branch/jump taken; refetch from redirect_pc
- redirect_pc  in  XLEN  byte address of the redirect target
- fe_valid  out  1  fe_inst/fe_pc are a real instruction
- fe_inst  out  XLEN  fetched instruction
- fe_pc  out  XLEN  byte address of fe_inst
- halted  out  1  FSM in HALT

Behaviour:
- Reset (RSTN_N=1 at an edge):
  - state=IDLE, pc=RESET_PC
  - fe_valid=0, fe_inst=0, fe_pc=0, halted=0
  - Memory contents are not cleared.
  - Reset has priority over every other input, including mid-run.
- Memory:
  - The write takes effect at the edge when wr_en=1.
  - The read is combinational on mem[pc[AW+1:2]]. If a read and a write hit the same index in the same cycle, the read returns the OLD word.
  - Writes are legal in all states.
- Addressing:
  - PC is a byte address; pc[1:0] is ignored.
  - The index wraps modulo DEPTH, so pc=4*DEPTH reads word 0.
  - pc+4 wraps at 2^XLEN.
- IDLE:
  - fe_valid=0.
  - start=1 -> pc<=RESET_PC, go to RUN. The first valid output appears on the following cycle.
  - redirect is ignored.
- RUN, evaluated in this priority order:
  1. redirect=1 -> pc<=redirect_pc, fe_valid<=0 (one bubble); stall is ignored this cycle. The instruction at redirect_pc appears with fe_valid=1 one cycle later if stall=0.
  2. stall=1 -> pc, fe_valid, fe_inst and fe_pc all hold.
  3. Fetched word==HALT_INST -> go to HALT, fe_valid<=0. The halt word is never presented and pc holds.
  4. Otherwise -> fe_inst<=mem[idx], fe_pc<=pc, fe_valid<=1, pc<=pc+4.
- Latency: one cycle from pc to fe_* outputs. Throughput is one instruction per cycle when stall=0.
- HALT:
  - halted=1, fe_valid=0.
  - redirect=1 -> pc<=redirect_pc, go to RUN, halted<=0.
  - start is ignored.
  - Only reset or redirect leaves HALT.
- Overlapping inputs:
  - start while in RUN is ignored.
  - redirect and stall together: redirect wins and outputs are invalidated.
- fe_inst/fe_pc may hold stale values when fe_valid=0; the consumer ignores them.

Test Plan:
- Load words 0..4 = 32'h11,22,33,44,HALT_INST, then pulse start. Required: fe_valid=1 on cycles 1-4 with (fe_pc, fe_inst) = (0,11), (4,22), (8,33), (12,44). Cycle 5: fe_valid=0, halted=1.
- Same program with stall=1 asserted for 3 cycles while fe_pc=4. Required: fe_inst=22 and fe_pc=4 held for 3 cycles, then 33 at pc 8; no instruction is skipped or duplicated.
- During RUN at fe_pc=8, assert redirect=1 with redirect_pc=0 and stall=1 simultaneously. Required: next cycle fe_valid=0; following cycle fe_pc=0, fe_inst=11.
- In HALT, redirect to pc 4. Required: halted=0, then fe_inst=22 at pc 4. Next, redirect_pc=4*DEPTH=128 with word 0=11. Required: fe_pc=128, fe_inst=11 (wrap).
- Write word 2=55 in the same cycle pc=8 is read. Required: fe_inst=33 (old word). After redirect to 8: fe_inst=55.
- Assert reset mid-run at fe_pc=12. Required: next cycle fe_valid=0, state IDLE, memory intact. A later start refetches from 0 with fe_inst=11.
